tis_stack_node: RTL
===================

# tis_stack_node

Shared LIFO memory node for the TIS core mesh: up to four neighbouring cores (left, right, up, down) push and pop 11-bit signed values to one stack. A round-robin arbiter serialises requests to one operation per cycle. Full/empty block only the affected requests, matching TIS blocking-port semantics. It sits in the mesh where a core would otherwise sit, wired to the cores' directional ports.

## Interface
- WIDTH, 11: data width; two's-complement value range of a core accumulator.
- DEPTH, 15: stack capacity in entries, 1..255.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- push_req  in  4  per-side push request; bit 0=L, 1=R, 2=U, 3=D.
- push_data  in  4*WIDTH  per-side push value; side i at [WIDTH*i+WIDTH-1 : WIDTH*i].
- push_ack  out  4  one-cycle pulse: side's push accepted.
- pop_req  in  4  per-side pop request, same bit order.
- pop_valid  out  4  one-cycle pulse: pop_data holds the popped value for that side.
- pop_data  out  WIDTH  popped value; meaningful only while a pop_valid bit is high.
- count  out  8  current number of entries, 0..DEPTH.

## Operation
- Storage: DEPTH x WIDTH register array plus `count`. Top of stack is entry count-1.
- Request eligibility, evaluated each cycle:
  - push from side i: push_req[i] and count<DEPTH and push_ack[i]=0 and pop_valid[i]=0.
  - pop from side i: pop_req[i] and count>0 and push_ack[i]=0 and pop_valid[i]=0.
  - Masking a side whose ack/valid is currently high prevents double service while the requester drops its request.
- A side with both push_req and pop_req high is treated as a push only; its pop is ignored that cycle.
- Arbitration: round-robin over sides using a 2-bit pointer `ptr`.
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first eligible side wins.
  - After a grant, ptr = winner+1 mod 4. With no grant, ptr holds.
- At most one grant per cycle, so count changes by at most 1 per cycle.
- Push grant to side i:
  - mem[count] <= push_data slice i; count <= count+1.
  - push_ack <= one-hot(i) next cycle.
- Pop grant to side i:
  - pop_data <= mem[count-1]; count <= count-1.
  - pop_valid <= one-hot(i) next cycle.
- Data passes bit-exact; there is no arithmetic on values and no saturation.
- Blocked requests (full or empty) simply wait. Other sides' eligible requests are still served, so there is no head-of-line blocking.
- Requester protocol:
  - Assert req (with stable data for a push) and hold it until the ack/valid pulse is sampled high.
  - Deassert on the following cycle, or re-assert immediately for back-to-back operations.
  - A request dropped before its ack is a protocol violation; behaviour is undefined but must not corrupt count.

## Timing
- Reset (rst high at a rising edge): count=0, ptr=0, push_ack=0, pop_valid=0, pop_data=0. Stack contents are don't-care.
- Reset mid-operation: pending requests and in-flight acks are discarded. Outputs are all 0 in the cycle after the reset edge.
- Latency: request sampled at edge k → ack/valid high in cycle k..k+1, count updated at edge k.
- The same side can be granted at most every 2nd cycle. Different sides can be granted in consecutive cycles.
- Full (count=DEPTH): no push grants; pops remain eligible. Empty (count=0): no pop grants; pushes remain eligible.
- Simultaneous push on one side and pop on another: resolved only by round-robin order. The stack is never bypassed; a pop never returns a value in the same cycle it is pushed.
- A pop_valid pulse and a push_ack pulse to different sides never coincide, because there is one grant per cycle.

## Test plan
- Reset then idle: rst for 2 cycles → count=0, all acks 0, pop_data=0. Pop_req[0] held 5 cycles while empty → no pop_valid.
- LIFO order: L pushes 5, 3, -7 sequentially → three push_ack[0] pulses, count=3. Then R pops three times → pop_data -7, 3, 5 on pop_valid[1]; count=0.
- Full blocking (DEPTH=15): push 15 values from U → count=15. 16th push_req[2] held → no ack. D pops once → returns the 15th value. U's push is then acked on a later cycle, count=15.
- Round-robin fairness: all four sides hold push_req from count=0, ptr=0 → acks in order L, R, U, D on consecutive cycles. Repeated, each side gets exactly one ack per 4 grants.
- Mixed contention: count=1 (value 42). Same cycle: L pops, R pushes 9, ptr=0 → L receives 42, then R acked, count=1, top=9.
- Reset mid-burst: assert rst while push_ack[3] is high and count=4 → next cycle count=0, push_ack=0, and later pops block until a new push.

Source files
------------

// File: rtl/tis_stack_node.sv
// Shared LIFO stack node for the TIS core mesh. Four neighbouring cores push and pop through a
// round-robin arbiter that grants at most one operation per cycle.
module tis_stack_node #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [3:0]             i_push_req,
  input  logic [4*WIDTH-1:0]     i_push_data,
  output logic [3:0]             o_push_ack,
  input  logic [3:0]             i_pop_req,
  output logic [3:0]             o_pop_valid,
  output logic [WIDTH-1:0]       o_pop_data,
  output logic [7:0]             o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DepthC = 8'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [7:0]       r_count;
  logic [1:0]       r_ptr;
  logic [3:0]       r_push_ack;
  logic [3:0]       r_pop_valid;
  logic [WIDTH-1:0] r_pop_data;

  logic [3:0]    w_busy;
  logic [3:0]    w_push_elig;
  logic [3:0]    w_pop_elig;
  logic [3:0]    w_elig;
  logic          w_not_full;
  logic          w_not_empty;
  logic          w_gnt_valid;
  logic [1:0]    w_gnt_idx;
  logic [1:0]    w_cand;
  logic          w_gnt_push;
  logic          w_gnt_pop;
  logic [7:0]    w_top;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  // A side still showing its ack/valid is masked so a held request is not served twice.
  assign w_busy      = r_push_ack | r_pop_valid;
  assign w_not_full  = (r_count < DepthC);
  assign w_not_empty = (r_count != 8'd0);
  assign w_push_elig = i_push_req & ~w_busy & {4{w_not_full}};
  assign w_pop_elig  = i_pop_req & ~i_push_req & ~w_busy & {4{w_not_empty}};
  assign w_elig      = w_push_elig | w_pop_elig;

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = r_ptr;
    w_cand      = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_gnt_valid && w_elig[w_cand]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  assign w_gnt_push = w_gnt_valid && w_push_elig[w_gnt_idx];
  assign w_gnt_pop  = w_gnt_valid && w_pop_elig[w_gnt_idx];
  assign w_top      = r_count - 8'd1;
  assign w_wr_idx   = r_count[AW-1:0];
  assign w_rd_idx   = w_top[AW-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count     <= 8'd0;
      r_ptr       <= 2'd0;
      r_push_ack  <= 4'd0;
      r_pop_valid <= 4'd0;
      r_pop_data  <= '0;
    end else begin
      r_push_ack  <= 4'd0;
      r_pop_valid <= 4'd0;
      if (w_gnt_push) begin
        r_count    <= r_count + 8'd1;
        r_push_ack <= 4'b0001 << w_gnt_idx;
        r_ptr      <= w_gnt_idx + 2'd1;
      end else if (w_gnt_pop) begin
        r_count     <= w_top;
        r_pop_valid <= 4'b0001 << w_gnt_idx;
        r_pop_data  <= r_mem[w_rd_idx];
        r_ptr       <= w_gnt_idx + 2'd1;
      end
    end
  end

  // Contents are not reset; only entries below count are ever read.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_gnt_push) begin
      r_mem[w_wr_idx] <= i_push_data[WIDTH*w_gnt_idx +: WIDTH];
    end
  end

  assign o_push_ack  = r_push_ack;
  assign o_pop_valid = r_pop_valid;
  assign o_pop_data  = r_pop_data;
  assign o_count     = r_count;

endmodule
